// File: rtl/qupls4_chkpt_alloc_mp_if.sv
// Decode-side handshake and status bundle for the checkpoint allocator.
interface qupls4_chkpt_alloc_mp_if #(
    parameter int NCHECK = 16,
    parameter int NSLOT  = 4,
    parameter int NFREE  = 2
);
    localparam int CW = $clog2(NCHECK);

    logic                         alloc;
    logic [NSLOT-1:0]             br;
    logic [NFREE-1:0]             free;
    logic [NFREE-1:0][CW-1:0]     fchkpt;
    logic [NCHECK-1:0]            free_mask;
    logic                         flush;

    logic [NSLOT-1:0][CW-1:0]     chkptn;
    logic                         stall;
    logic [NCHECK-1:0]            avail;
    logic [CW:0]                  count;
    logic                         err;

    modport master (
        output alloc, br, free, fchkpt, free_mask, flush,
        input  chkptn, stall, avail, count, err
    );

    modport slave (
        input  alloc, br, free, fchkpt, free_mask, flush,
        output chkptn, stall, avail, count, err
    );
endinterface

// File: rtl/qupls4_chkpt_alloc_mp.sv
// Multi-port branch checkpoint allocator: lowest-free-first, one-cycle alloc/free latency.
// Backpressure: combinational stall when the group needs more checkpoints than are free.
module qupls4_chkpt_alloc_mp #(
    parameter int NCHECK   = 16,
    parameter int NSLOT    = 4,
    parameter int NFREE    = 2,
    parameter int RESERVE0 = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    qupls4_chkpt_alloc_mp_if.slave    bus
);
    localparam int CW = $clog2(NCHECK);
    localparam logic [NCHECK-1:0] INIT_AVAIL =
        {{(NCHECK-1){1'b1}}, (RESERVE0 != 0) ? 1'b0 : 1'b1};
    localparam logic [CW:0] INIT_COUNT = (CW+1)'(NCHECK - ((RESERVE0 != 0) ? 1 : 0));

    logic [NCHECK-1:0]          avail_q;
    logic [CW:0]                count_q;
    logic [CW-1:0]              lastc_q;
    logic [NSLOT-1:0][CW-1:0]   chkptn_q;
    logic                       err_q;

    logic [NSLOT-1:0][CW-1:0]   cand;
    logic [NSLOT-1:0]           cand_vld;
    logic [NCHECK-1:0]          scan;

    logic [NSLOT-1:0][CW-1:0]   slot_chk;
    logic [NCHECK-1:0]          alloc_clr;
    logic [CW-1:0]              run_chk;
    logic [CW:0]                need;
    int                         k;

    logic [NCHECK-1:0]          free_set;
    logic                       dbl;
    logic [NCHECK-1:0]          avail_nxt;
    logic [CW:0]                count_nxt;
    logic                       accept;

    // Priority chain: each stage takes the lowest bit left over by the stages before it.
    always_comb begin
        scan     = avail_q;
        cand     = '0;
        cand_vld = '0;
        for (int c = 0; c < NSLOT; c++) begin
            cand_vld[c] = |scan;
            for (int j = NCHECK - 1; j >= 0; j--) begin
                if (scan[j]) begin
                    cand[c] = CW'(j);
                end
            end
            if (cand_vld[c]) begin
                scan[cand[c]] = 1'b0;
            end
        end
    end

    // Branch slots consume candidates in slot order; other slots inherit the
    // nearest lower branch's checkpoint, or the previous group's last one.
    always_comb begin
        k         = 0;
        run_chk   = lastc_q;
        alloc_clr = '0;
        slot_chk  = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (bus.br[s]) begin
                if (cand_vld[k]) begin
                    alloc_clr[cand[k]] = 1'b1;
                end
                run_chk = cand[k];
                k       = k + 1;
            end
            slot_chk[s] = run_chk;
        end
        need = (CW+1)'(k);
    end

    assign bus.stall = bus.alloc & (need > count_q) & ~bus.flush;
    assign accept    = bus.alloc & ~bus.stall & ~bus.flush;

    // A free is a double-free if the bit is already free or was freed earlier this cycle.
    always_comb begin
        free_set = bus.free_mask;
        dbl      = |(bus.free_mask & avail_q);
        if ((RESERVE0 != 0) && bus.free_mask[0]) begin
            dbl         = 1'b1;
            free_set[0] = 1'b0;
        end
        for (int p = 0; p < NFREE; p++) begin
            if (bus.free[p]) begin
                if ((RESERVE0 != 0) && (bus.fchkpt[p] == '0)) begin
                    dbl = 1'b1;
                end else begin
                    if (avail_q[bus.fchkpt[p]] || free_set[bus.fchkpt[p]]) begin
                        dbl = 1'b1;
                    end
                    free_set[bus.fchkpt[p]] = 1'b1;
                end
            end
        end
    end

    // Allocation wins over a same-cycle free of the same bit.
    always_comb begin
        avail_nxt = (avail_q | free_set) & ~(accept ? alloc_clr : '0);
        count_nxt = '0;
        for (int i = 0; i < NCHECK; i++) begin
            count_nxt = count_nxt + (CW+1)'(avail_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avail_q  <= INIT_AVAIL;
            count_q  <= INIT_COUNT;
            lastc_q  <= '0;
            chkptn_q <= '0;
            err_q    <= 1'b0;
        end else if (bus.flush) begin
            avail_q  <= INIT_AVAIL;
            count_q  <= INIT_COUNT;
            lastc_q  <= '0;
            chkptn_q <= '0;
        end else begin
            avail_q <= avail_nxt;
            count_q <= count_nxt;
            if (dbl) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                chkptn_q <= slot_chk;
                lastc_q  <= run_chk;
            end
        end
    end

    assign bus.chkptn = chkptn_q;
    assign bus.avail  = avail_q;
    assign bus.count  = count_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_qupls4_chkpt_alloc_mp.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
module tb_qupls4_chkpt_alloc_mp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qupls4_chkpt_alloc_mp_if #(.NCHECK(16), .NSLOT(4), .NFREE(2)) bus ();

    qupls4_chkpt_alloc_mp #(
        .NCHECK(16), .NSLOT(4), .NFREE(2), .RESERVE0(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [4:0] M_S = 5'b00001;
    localparam logic [4:0] M_A = 5'b00010;
    localparam logic [4:0] M_C = 5'b00100;
    localparam logic [4:0] M_K = 5'b01000;
    localparam logic [4:0] M_E = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string       name;
        logic [4:0]  m;
        logic        stall;
        logic [15:0] avail;
        logic [4:0]  count;
        logic [15:0] chk;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [15:0] ch(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%04h required=0x%04h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.m[0]) cmp(e.name, "stall", 16'(bus.stall), 16'(e.stall));
            if (e.m[1]) cmp(e.name, "avail", bus.avail, e.avail);
            if (e.m[2]) cmp(e.name, "count", 16'(bus.count), 16'(e.count));
            if (e.m[3]) cmp(e.name, "chkptn", bus.chkptn, e.chk);
            if (e.m[4]) cmp(e.name, "err", 16'(bus.err), 16'(e.err));
        end
    end

    task automatic drive(input logic r, input logic a, input logic [3:0] br,
                         input logic [1:0] fv, input logic [3:0] f0, input logic [3:0] f1,
                         input logic [15:0] fm, input logic fl);
        @(posedge clk);
        #1;
        rst           = r;
        bus.alloc     = a;
        bus.br        = br;
        bus.free      = fv;
        bus.fchkpt[0] = f0;
        bus.fchkpt[1] = f1;
        bus.free_mask = fm;
        bus.flush     = fl;
    endtask

    task automatic expect_out(input string nm, input logic [4:0] m, input logic st,
                              input logic [15:0] av, input logic [4:0] cnt,
                              input logic [15:0] chv, input logic e);
        exp_t x;
        x.name = nm; x.m = m; x.stall = st; x.avail = av;
        x.count = cnt; x.chk = chv; x.err = e;
        sb.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc = 1'b0; bus.br = '0; bus.free = '0; bus.fchkpt = '0;
        bus.free_mask = '0; bus.flush = 1'b0;

        drive(1, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("reset", M_ALL, 0, 16'hFFFE, 15, ch(0,0,0,0), 0);

        // Mixed branch/non-branch group, then an all-non-branch group.
        drive(0, 1, 4'b0101, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("alloc0101_in", M_S, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("alloc0101", M_S|M_A|M_C|M_K, 0, 16'hFFF8, 13, ch(1,1,2,2), 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("nobranch", M_A|M_C|M_K, 0, 16'hFFF8, 13, ch(2,2,2,2), 0);

        // Mid-operation reset, then exhaustion.
        drive(1, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("midop_reset", M_ALL, 0, 16'hFFFE, 15, ch(0,0,0,0), 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("grp1", M_S|M_A|M_C|M_K, 0, 16'hFFE0, 11, ch(1,2,3,4), 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("grp2", M_S|M_A|M_C|M_K, 0, 16'hFE00, 7, ch(5,6,7,8), 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("grp3_full", M_S|M_A|M_C|M_K, 1, 16'hE000, 3, ch(9,10,11,12), 0);
        drive(0, 1, 4'b1111, 2'b01, 5, 0, 16'h0000, 0);
        expect_out("stall_hold", M_S|M_A|M_C|M_K, 1, 16'hE000, 3, ch(9,10,11,12), 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("free5", M_S|M_A|M_C, 0, 16'hE020, 4, 0, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("after_free", M_A|M_C|M_K|M_E, 0, 16'h0000, 0, ch(5,13,14,15), 0);

        // Double free across ports, then a free of the reserved checkpoint.
        drive(0, 0, 4'b0000, 2'b11, 7, 7, 16'h0000, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("dbl_free", M_A|M_C|M_E, 0, 16'h0080, 1, 0, 1);
        drive(0, 0, 4'b0000, 2'b01, 0, 0, 16'h0000, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("free_zero", M_A|M_C|M_E, 0, 16'h0080, 1, 0, 1);

        // Flush overrides alloc and mask free.
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0010, 1);
        expect_out("flush_stall", M_S, 0, 0, 0, 0, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("flush", M_A|M_C|M_K|M_E, 0, 16'hFFFE, 15, ch(0,0,0,0), 1);

        // Drain to zero, then a mask free is not allocatable the same cycle.
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("drain1", M_S, 0, 0, 0, 0, 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        drive(0, 1, 4'b1111, 2'b00, 0, 0, 16'h0000, 0);
        drive(0, 1, 4'b0111, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("drain4", M_S|M_C, 0, 0, 3, 0, 0);
        drive(0, 1, 4'b0011, 2'b00, 0, 0, 16'h0006, 0);
        expect_out("mask_stall", M_S|M_A|M_C|M_K, 1, 16'h0000, 0, ch(13,14,15,15), 0);
        drive(0, 1, 4'b0011, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("mask_free", M_S|M_A|M_C, 0, 16'h0006, 2, 0, 0);
        drive(0, 0, 4'b0000, 2'b00, 0, 0, 16'h0000, 0);
        expect_out("mask_alloc", M_A|M_C|M_K, 0, 16'h0000, 0, ch(1,2,2,2), 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
